// File: rtl/snappy_pkg.sv
// rtl/snappy_pkg.sv - shared token layout for the snappy copy-read path
package snappy_pkg;

    localparam int TOKEN_W      = 33;
    localparam int TOK_ADDR_LSB = 24;
    localparam int TOK_MASK_LSB = 16;

    // Field order matches the packed bit layout {address, mask, offset}
    typedef struct packed {
        logic [8:0]  address;
        logic [7:0]  mask;
        logic [15:0] offset;
    } unsolved_token_t;

endpackage

// File: rtl/unsolved_token_queue_if.sv
// rtl/unsolved_token_queue_if.sv - token in / reissue out bundle for the retry queue
interface unsolved_token_queue_if
    import snappy_pkg::*;
#(
    parameter int DEPTH = 16
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic               flush;
    logic               token_valid_in;
    logic [TOKEN_W-1:0] token_in;
    logic               slot_free;
    logic               reissue_valid;
    logic [8:0]         reissue_address;
    logic [7:0]         reissue_mask;
    logic [15:0]        reissue_offset;
    logic               stall_out;
    logic               drained;
    logic               overflow_err;
    logic [CW-1:0]      count;

    modport master (
        output flush, token_valid_in, token_in, slot_free,
        input  reissue_valid, reissue_address, reissue_mask, reissue_offset,
        input  stall_out, drained, overflow_err, count
    );

    modport slave (
        input  flush, token_valid_in, token_in, slot_free,
        output reissue_valid, reissue_address, reissue_mask, reissue_offset,
        output stall_out, drained, overflow_err, count
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO, distributed RAM plus registered head
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // Bypass the write when the incoming entry becomes the next head
            if (push && (wr_ptr_q == rd_ptr_d)) head_d = wdata;
            else                                head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign rdata = head_q;
    assign count = count_q;

endmodule

// File: rtl/unsolved_token_queue.sv
// rtl/unsolved_token_queue.sv - retry queue re-issuing unsolved copy tokens on idle read slots
module unsolved_token_queue
    import snappy_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    unsolved_token_queue_if.slave q
);

    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    unsolved_token_t tok_in;
    unsolved_token_t head;
    logic [CW-1:0]   fifo_count;
    logic            push_req, push, pop, full;
    logic            ovf_q, ovf_d;
    logic [2:0]      inflight_q, inflight_d;

    assign tok_in   = q.token_in;
    assign full     = (fifo_count == FULL_CNT);
    assign push_req = q.token_valid_in && (tok_in.mask != 8'h00) && !q.flush;
    assign pop      = q.slot_free && (fifo_count != '0) && !q.flush;
    // A full queue still accepts when the head leaves in the same cycle
    assign push     = push_req && (!full || pop);

    always_comb begin
        ovf_d      = ovf_q;
        inflight_d = {inflight_q[1:0], pop};
        if (q.flush) begin
            ovf_d      = 1'b0;
            inflight_d = 3'b000;
        end else if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q      <= 1'b0;
            inflight_q <= 3'b000;
        end else begin
            ovf_q      <= ovf_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (TOKEN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (q.flush),
        .push  (push),
        .wdata (tok_in),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    assign q.reissue_valid   = pop;
    assign q.reissue_address = head.address;
    assign q.reissue_mask    = head.mask;
    assign q.reissue_offset  = head.offset;
    assign q.stall_out       = (fifo_count >= AF_CNT);
    assign q.drained         = (fifo_count == '0) && (inflight_q == 3'b000) && !q.token_valid_in;
    assign q.overflow_err    = ovf_q;
    assign q.count           = fifo_count;

endmodule

// File: tb/tb_unsolved_token_queue.sv
// tb/tb_unsolved_token_queue.sv - randomized bench against a queue-based reference model
module tb_unsolved_token_queue;

    localparam int DEPTH = 16;
    localparam int AFM   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unsolved_token_queue_if #(.DEPTH(DEPTH)) bus ();

    unsolved_token_queue #(.DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] mq[$];
    bit          m_ovf  = 1'b0;
    int          m_last = 3;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] rand_tok(input bit allow_zero);
        logic [8:0]  a;
        logic [7:0]  m;
        logic [15:0] o;
        a = 9'($urandom);
        m = 8'($urandom);
        o = 16'($urandom);
        if (!allow_zero && m == 8'h00) m = 8'h01;
        return {a, m, o};
    endfunction

    // One clock cycle: drive, compare against model, advance model
    task automatic step(input bit rst, input bit fl, input bit tv, input logic [32:0] tok, input bit sf);
        bit          exp_valid, push_req, was_full;
        logic [32:0] hd;
        rst_n              = !rst;
        bus.flush          = fl;
        bus.token_valid_in = tv;
        bus.token_in       = tok;
        bus.slot_free      = sf;
        #3;
        exp_valid = sf && (mq.size() != 0) && !fl;
        check_eq("reissue_valid", 64'(bus.reissue_valid), 64'(exp_valid));
        if (exp_valid) begin
            hd = mq[0];
            check_eq("reissue_address", 64'(bus.reissue_address), 64'(hd[32:24]));
            check_eq("reissue_mask",    64'(bus.reissue_mask),    64'(hd[23:16]));
            check_eq("reissue_offset",  64'(bus.reissue_offset),  64'(hd[15:0]));
        end
        check_eq("count",        64'(bus.count),        64'(mq.size()));
        check_eq("stall_out",    64'(bus.stall_out),    64'(mq.size() >= DEPTH - AFM));
        check_eq("drained",      64'(bus.drained),      64'((mq.size() == 0) && (m_last >= 3) && !tv));
        check_eq("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
        if (rst || fl) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_last = 3;
        end else begin
            push_req = tv && (tok[23:16] != 8'h00);
            was_full = (mq.size() == DEPTH);
            if (exp_valid) void'(mq.pop_front());
            if (push_req) begin
                if (!was_full || exp_valid) mq.push_back(tok);
                else                        m_ovf = 1'b1;
            end
            if (exp_valid)       m_last = 0;
            else if (m_last < 3) m_last++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.flush          = 1'b0;
        bus.token_valid_in = 1'b0;
        bus.token_in       = '0;
        bus.slot_free      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic retry
        step(0, 0, 1, {9'h005, 8'h0F, 16'd12}, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1);

        // zero-mask token is discarded
        step(0, 0, 1, {9'h1AB, 8'h00, 16'd7}, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);

        // fill to almost-full, then full, then overflow
        for (int i = 0; i < 12; i++) step(0, 0, 1, rand_tok(0), 0);
        for (int i = 0; i < 4; i++)  step(0, 0, 1, rand_tok(0), 0);
        step(0, 0, 1, rand_tok(0), 0);
        step(0, 0, 0, '0, 0);
        // push and pop together while full
        step(0, 0, 1, rand_tok(0), 1);
        for (int i = 0; i < 18; i++) step(0, 0, 0, '0, 1);

        // flush with 7 queued and overflow still set, colliding with a push
        for (int i = 0; i < 7; i++) step(0, 0, 1, rand_tok(0), 0);
        step(0, 1, 1, rand_tok(0), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1);

        // random traffic across pointer wrap with occupancy held in 1..15
        step(0, 0, 1, rand_tok(0), 0);
        for (int i = 0; i < 40; i++) begin
            bit tv, sf;
            tv = ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH - 1);
            sf = ($urandom_range(0, 1) != 0) && (mq.size() > 1);
            step(0, 0, tv, rand_tok($urandom_range(0, 7) == 0), sf);
        end
        for (int i = 0; i < 18; i++) step(0, 0, 0, '0, 1);

        // reset mid-operation
        for (int i = 0; i < 5; i++) step(0, 0, 1, rand_tok(0), 0);
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
